bus_memory_unit: RTL and testbench
==================================

# bus_memory_unit

Data-side bus slave sitting directly downstream of the accumulator processor controller. It consumes the controller's 95-bit output word, serves load/store requests from a single-port 32-bit word RAM plus a small memory-mapped I/O window, and returns read data on `busOut` with one-cycle latency, which is the cycle in which the controller's stage 2 consumes `busIn`. It also latches the controller's exit flag into a sticky `halted` status.

## Interface
Parameters:
- `IO_BASE`, default 8'hF0: first I/O address. RAM occupies addresses 0 .. IO_BASE-1, and I/O occupies IO_BASE .. 8'hFF.

Ports:
- `CLK` input 1: single clock; all state updates on posedge.
- `RST` input 1: reset, synchronous, active-high.
- `ctrlIn` input 95: controller output word.
  - [94:87] addr.
  - [86] read.
  - [85] write.
  - [84:53] wdata.
  - [52:21] acc (debug, unused).
  - [20:17] pc (debug, unused).
  - [16:1] instr (debug, unused).
  - [0] exit.
- `portIn` input 32: external input port, sampled on reads of IO_BASE+1.
- `busOut` output 32: read data, wired to the controller's `busIn`.
- `portOut` output 32: external output port register.
- `halted` output 1: sticky halt status.

## Operation
Address decode (addr = `ctrlIn[94:87]`):
- addr < IO_BASE: RAM word, read/write.
- IO_BASE+0: `portOut` register, read/write.
- IO_BASE+1: `portIn`. Reads return `portIn` sampled at the request edge. Writes are ignored.
- IO_BASE+2: `timer`. Reads return the pre-edge value. Writes load wdata.
- IO_BASE+3: `wrCount`, the count of accepted writes. Read-only; writes to it are ignored and are not counted.
- IO_BASE+4 .. 8'hFF: reads return 0; writes are ignored and are not counted.

Reads:
- When read=1, `busOut` is updated at the edge with the selected value.
- When read=0, `busOut` holds its last value.

Writes:
- When write=1 and `halted`=0, the target is updated at the edge.
- `wrCount` increments (wrapping at 2^32) for every write that lands on RAM, `portOut` or `timer`.

Simultaneous read and write to the same address:
- Read-before-write: `busOut` receives the old value.
- The new value is committed at the same edge.

Timer:
- Increments by 1 each cycle while `halted`=0, wrapping 32'hFFFFFFFF -> 0.
- A write load wins over the increment in the same cycle.
- While `halted`=1 the timer is frozen.

Halt:
- `halted` is set at the edge where `ctrlIn[0]`=1, and stays set until `RST`.
- A write in the same cycle as exit=1 is still accepted, because `halted` was still 0 when it was sampled.
- While `halted`=1:
  - all writes are dropped;
  - `wrCount` is frozen;
  - reads are still served.

Reset, at the `RST` edge:
- `busOut`, `portOut`, `timer` and `wrCount` go to 0, and `halted` goes to 0.
- RAM contents are not cleared; they are undefined until first written.
- `RST` overrides all requests in the same cycle.
- A read request pending when `RST` is asserted is discarded; `busOut` is 0 afterwards.

## Timing
- Read latency is 1 cycle: a request sampled at edge N gives `busOut` valid from after edge N through edge N+1, i.e. during the controller's stage-2 cycle.
- Write commit is at the sampling edge. A read of the same address in the next cycle returns the new data.
- Back-to-back reads on every cycle are supported at full throughput, with no stalls and no handshake. The controller never waits, so the block must accept a request every cycle.
- `portOut` and `halted` change only at posedge, so they are glitch-free registered outputs.
- `timer` value on a read is the value held before edge N. For example, after reset deassertion the first read returns the number of cycles elapsed since reset.

## Test plan
- **Reset:** hold `RST` 2 cycles with read=1, addr=IO_BASE+2 -> `busOut`=0, `portOut`=0, `halted`=0; timer reads 0 on the first post-reset read.
- **RAM round-trip:**
  - Write 32'hDEADBEEF to addr 8'h05, then read 8'h05 next cycle -> `busOut`=32'hDEADBEEF one cycle after the read.
  - Read-and-write same cycle to 8'h05 with 32'h1 -> `busOut`=32'hDEADBEEF; a following read returns 32'h1.
- **I/O window:**
  - Write 32'hA5 to IO_BASE -> `portOut`=32'hA5 next cycle.
  - Set `portIn`=32'h1234 and read IO_BASE+1 -> 32'h1234.
  - Write to IO_BASE+1 -> `wrCount` unchanged.
  - Read 8'hFF -> 0.
- **Timer:**
  - Load 32'hFFFFFFFE via a write to IO_BASE+2, idle 1 cycle, read -> 32'hFFFFFFFF; a read the following cycle -> 0 (wrap).
- **Halt:**
  - Drive exit=1 together with a write of 7 to addr 8'h10 -> `halted`=1 and RAM[8'h10]=7.
  - A subsequent write of 9 to 8'h10 is dropped; a read returns 7.
  - Timer and `wrCount` stay frozen across 10 cycles.
- **Integration:** run the controller's built-in program with this block attached -> every load observes the data stored by the preceding store. `halted` asserts on the exit instruction and is cleared only by `RST`.

Source files
------------

// File: rtl/bus_memory_unit.sv
// Data-side bus slave for the accumulator controller: word RAM below IO_BASE,
// a small memory-mapped I/O window above it, one-cycle read data and a sticky halt flag.
module bus_memory_unit #(
    parameter logic [7:0] IO_BASE = 8'hF0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [94:0] ctrlIn,
    input  logic [31:0] portIn,
    output logic [31:0] busOut,
    output logic [31:0] portOut,
    output logic        halted
);

    localparam int unsigned DW        = 32;
    localparam int unsigned RAM_DEPTH = 32'(IO_BASE);
    localparam int unsigned AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    localparam logic [7:0] ADDR_PORT_OUT = IO_BASE;
    localparam logic [7:0] ADDR_PORT_IN  = IO_BASE + 8'd1;
    localparam logic [7:0] ADDR_TIMER    = IO_BASE + 8'd2;
    localparam logic [7:0] ADDR_WR_COUNT = IO_BASE + 8'd3;

    // Controller word fields
    logic [7:0]    addr;
    logic          rd_req;
    logic          wr_req;
    logic [DW-1:0] wdata;
    logic          exit_req;
    logic          unused_debug;

    assign addr         = ctrlIn[94:87];
    assign rd_req       = ctrlIn[86];
    assign wr_req       = ctrlIn[85];
    assign wdata        = ctrlIn[84:53];
    assign exit_req     = ctrlIn[0];
    // acc/pc/instr are debug-only fields of the controller word
    assign unused_debug = ^ctrlIn[52:1];

    logic [DW-1:0] ram [RAM_DEPTH];
    logic [DW-1:0] timer;
    logic [DW-1:0] wrCount;

    logic [AW-1:0] ram_idx_c;
    logic          is_ram_c;
    logic          wr_ok_c;
    logic          wr_ram_c;
    logic          wr_port_c;
    logic          wr_timer_c;
    logic          wr_counted_c;
    logic [DW-1:0] rd_data_c;

    // Address decode and write qualification; halted is the pre-edge value
    always_comb begin
        ram_idx_c    = AW'(addr);
        is_ram_c     = (addr < IO_BASE);
        wr_ok_c      = wr_req && !halted;
        wr_ram_c     = wr_ok_c && is_ram_c;
        wr_port_c    = wr_ok_c && (addr == ADDR_PORT_OUT);
        wr_timer_c   = wr_ok_c && (addr == ADDR_TIMER);
        wr_counted_c = wr_ram_c || wr_port_c || wr_timer_c;
    end

    // Read mux over pre-edge state gives read-before-write on same-address access
    always_comb begin
        rd_data_c = '0;
        if (is_ram_c) begin
            rd_data_c = ram[ram_idx_c];
        end else begin
            case (addr)
                ADDR_PORT_OUT: rd_data_c = portOut;
                ADDR_PORT_IN:  rd_data_c = portIn;
                ADDR_TIMER:    rd_data_c = timer;
                ADDR_WR_COUNT: rd_data_c = wrCount;
                default:       rd_data_c = '0;
            endcase
        end
    end

    // Status, I/O and read-data registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            busOut  <= '0;
            portOut <= '0;
            timer   <= '0;
            wrCount <= '0;
            halted  <= 1'b0;
        end else begin
            if (rd_req) begin
                busOut <= rd_data_c;
            end
            if (wr_port_c) begin
                portOut <= wdata;
            end
            if (wr_timer_c) begin
                timer <= wdata;
            end else if (!halted) begin
                timer <= timer + DW'(1);
            end
            if (wr_counted_c) begin
                wrCount <= wrCount + DW'(1);
            end
            if (exit_req) begin
                halted <= 1'b1;
            end
        end
    end

    // RAM has no reset; a reset cycle still blocks the write
    always_ff @(posedge CLK) begin
        if (!RST && wr_ram_c) begin
            ram[ram_idx_c] <= wdata;
        end
    end

endmodule

// File: tb/tb_bus_memory_unit.sv
// Bench for bus_memory_unit: directed test-plan sequence with literal expectations,
// then randomized traffic checked every cycle against a behavioural memory model.
module tb_bus_memory_unit;

    localparam logic [7:0] IO_BASE = 8'hF0;

    logic        CLK = 1'b0;
    logic        RST;
    logic [94:0] ctrlIn;
    logic [31:0] portIn;
    logic [31:0] busOut;
    logic [31:0] portOut;
    logic        halted;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    bus_memory_unit #(.IO_BASE(IO_BASE)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .ctrlIn (ctrlIn),
        .portIn (portIn),
        .busOut (busOut),
        .portOut(portOut),
        .halted (halted)
    );

    // Behavioural state of the bus slave
    logic [31:0] m_ram [256];
    bit          m_known [256];
    logic [31:0] m_bus, m_port, m_timer, m_wrc;
    bit          m_halt, m_bus_known, m_live;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a, input logic [31:0] pin);
        if (a < IO_BASE) return m_ram[a];
        case (8'(a - IO_BASE))
            8'd0:    return m_port;
            8'd1:    return pin;
            8'd2:    return m_timer;
            8'd3:    return m_wrc;
            default: return 32'h0;
        endcase
    endfunction

    // Model update at each edge, compare shortly after
    always @(posedge CLK) begin : model
        logic [7:0]  a;
        logic        rd, wr, ex;
        logic [31:0] wd, t_next;
        a  = ctrlIn[94:87];
        rd = ctrlIn[86];
        wr = ctrlIn[85];
        wd = ctrlIn[84:53];
        ex = ctrlIn[0];
        if (RST) begin
            m_bus = 0; m_port = 0; m_timer = 0; m_wrc = 0;
            m_halt = 0; m_bus_known = 1; m_live = 1;
        end else if (m_live) begin
            t_next = m_halt ? m_timer : m_timer + 32'd1;
            if (rd) begin
                m_bus       = model_read(a, portIn);
                m_bus_known = (a >= IO_BASE) || m_known[a];
            end
            if (wr && !m_halt) begin
                if (a < IO_BASE) begin
                    m_ram[a] = wd; m_known[a] = 1; m_wrc = m_wrc + 32'd1;
                end else if (a == IO_BASE) begin
                    m_port = wd; m_wrc = m_wrc + 32'd1;
                end else if (a == 8'(IO_BASE + 8'd2)) begin
                    t_next = wd; m_wrc = m_wrc + 32'd1;
                end
            end
            m_timer = t_next;
            if (ex) m_halt = 1;
        end
        #1;
        if (m_live) begin
            if (m_bus_known) check("busOut", busOut, m_bus);
            check("portOut", portOut, m_port);
            check("halted", {31'b0, halted}, {31'b0, m_halt});
        end
    end

    task automatic drive(input bit rst, input logic [7:0] a, input bit rd, input bit wr,
                         input logic [31:0] wd, input bit ex);
        logic [51:0] dbg;
        dbg = {$urandom, 20'($urandom)};
        @(negedge CLK);
        RST    = rst;
        ctrlIn = {a, rd, wr, wd, dbg, ex};
        @(posedge CLK);
        #2;
    endtask

    task automatic rd_at(input logic [7:0] a);
        drive(1'b0, a, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic wr_at(input logic [7:0] a, input logic [31:0] wd);
        drive(1'b0, a, 1'b0, 1'b1, wd, 1'b0);
    endtask

    initial begin
        logic [7:0] a;
        int         sel;
        m_live = 0;
        RST    = 1'b1;
        ctrlIn = '0;
        portIn = '0;

        // Reset with a pending timer read
        drive(1'b1, 8'hF2, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 8'hF2, 1'b1, 1'b0, 32'h0, 1'b0);
        check("rst_busOut", busOut, 32'h0);
        check("rst_portOut", portOut, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        rd_at(8'hF2);
        check("timer_first", busOut, 32'h0);

        // RAM round trip and read-before-write
        wr_at(8'h05, 32'hDEADBEEF);
        rd_at(8'h05);
        check("ram_rt", busOut, 32'hDEADBEEF);
        drive(1'b0, 8'h05, 1'b1, 1'b1, 32'h1, 1'b0);
        check("ram_rbw_old", busOut, 32'hDEADBEEF);
        rd_at(8'h05);
        check("ram_rbw_new", busOut, 32'h1);

        // I/O window
        wr_at(8'hF0, 32'hA5);
        check("portOut_wr", portOut, 32'hA5);
        portIn = 32'h1234;
        rd_at(8'hF1);
        check("portIn_rd", busOut, 32'h1234);
        wr_at(8'hF1, 32'h55);
        wr_at(8'hF3, 32'h77);
        wr_at(8'hFF, 32'h99);
        rd_at(8'hF3);
        check("wrCount_ign", busOut, 32'd3);
        rd_at(8'hFF);
        check("rd_hole", busOut, 32'h0);

        // Timer load and wrap
        wr_at(8'hF2, 32'hFFFFFFFE);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
        rd_at(8'hF2);
        check("timer_max", busOut, 32'hFFFFFFFF);
        rd_at(8'hF2);
        check("timer_wrap", busOut, 32'h0);

        // Halt with a same-cycle write, then frozen state
        drive(1'b0, 8'h10, 1'b0, 1'b1, 32'd7, 1'b1);
        check("halt_set", {31'b0, halted}, 32'h1);
        wr_at(8'h10, 32'd9);
        rd_at(8'h10);
        check("halt_drop", busOut, 32'd7);
        rd_at(8'hF2);
        check("halt_timer", busOut, 32'd2);
        for (int i = 0; i < 10; i++) begin
            wr_at(8'($urandom_range(0, 3) == 0 ? 8'hF0 : 8'($urandom_range(0, 8'hF3))), $urandom);
        end
        rd_at(8'hF2);
        check("frozen_timer", busOut, 32'd2);
        rd_at(8'hF3);
        check("frozen_wrc", busOut, 32'd5);
        rd_at(8'h10);
        check("frozen_ram", busOut, 32'd7);
        check("frozen_port", portOut, 32'hA5);

        // Reset clears halt and discards the pending read
        drive(1'b1, 8'h10, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 8'h10, 1'b0, 1'b0, 32'h0, 1'b0);
        check("rst2_halted", {31'b0, halted}, 32'h0);
        check("rst2_busOut", busOut, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)      a = 8'($urandom_range(0, 15));
            else if (sel < 8) a = 8'(IO_BASE + 8'($urandom_range(0, 5)));
            else              a = 8'($urandom_range(0, 255));
            portIn = $urandom;
            drive($urandom_range(0, 299) == 0, a, 1'($urandom), 1'($urandom), $urandom,
                  $urandom_range(0, 399) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
